// File: rtl/uart_alu_interface.sv
// Remote ALU command engine: gathers A, B and opcode bytes from the UART receiver,
// evaluates the ALU operation and hands one result byte to the UART transmitter.
module uart_alu_interface #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_rx_done_tick,
  input  logic [DBIT-1:0] i_rx_data,
  input  logic            i_tx_done_tick,
  output logic            o_tx_start,
  output logic [DBIT-1:0] o_tx_data,
  output logic            o_busy,
  output logic            o_op_error,
  output logic            o_overrun
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
  localparam logic [DBIT-1:0]  SHIFT_LIMIT = DBIT'(DBIT);

  function automatic logic op_supported(input logic [NB_OP-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  endfunction

  // Shift amounts at or beyond the byte width saturate instead of wrapping.
  function automatic logic [DBIT-1:0] alu(input logic [DBIT-1:0] a,
                                          input logic [DBIT-1:0] b,
                                          input logic [NB_OP-1:0] op);
    case (op)
      OP_ADD: alu = a + b;
      OP_SUB: alu = a - b;
      OP_AND: alu = a & b;
      OP_OR:  alu = a | b;
      OP_XOR: alu = a ^ b;
      OP_NOR: alu = ~(a | b);
      OP_SRA: begin
        if (b >= SHIFT_LIMIT) alu = {DBIT{a[DBIT-1]}};
        else                  alu = $signed(a) >>> b;
      end
      OP_SRL: begin
        if (b >= SHIFT_LIMIT) alu = {DBIT{1'b0}};
        else                  alu = a >> b;
      end
      default: alu = {DBIT{1'b0}};
    endcase
  endfunction

  state_t            state_r, state_n;
  logic [DBIT-1:0]   a_r, b_r, tx_data_r;
  logic              tx_start_r, busy_r, op_error_r, overrun_r;
  logic              load_a_s, load_b_s, load_op_s, drop_s;
  logic [NB_OP-1:0]  op_s;
  logic [DBIT-1:0]   result_s;
  logic              op_ok_s;

  assign op_s     = i_rx_data[NB_OP-1:0];
  assign result_s = alu(a_r, b_r, op_s);
  assign op_ok_s  = op_supported(op_s);

  // Next-state decode and per-byte load strobes.
  always_comb begin
    state_n   = state_r;
    load_a_s  = 1'b0;
    load_b_s  = 1'b0;
    load_op_s = 1'b0;
    drop_s    = 1'b0;
    case (state_r)
      WAIT_A: begin
        if (i_rx_done_tick) begin
          load_a_s = 1'b1;
          state_n  = WAIT_B;
        end else begin
          state_n  = WAIT_A;
        end
      end
      WAIT_B: begin
        if (i_rx_done_tick) begin
          load_b_s = 1'b1;
          state_n  = WAIT_OP;
        end else begin
          state_n  = WAIT_B;
        end
      end
      WAIT_OP: begin
        if (i_rx_done_tick) begin
          load_op_s = 1'b1;
          state_n   = SEND;
        end else begin
          state_n   = WAIT_OP;
        end
      end
      SEND: begin
        drop_s  = i_rx_done_tick;
        state_n = WAIT_TX;
      end
      WAIT_TX: begin
        drop_s = i_rx_done_tick;
        if (i_tx_done_tick) state_n = WAIT_A;
        else                state_n = WAIT_TX;
      end
      default: state_n = WAIT_A;
    endcase
  end

  // State, operand and registered-output update; outputs follow the next state.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r    <= WAIT_A;
      a_r        <= {DBIT{1'b0}};
      b_r        <= {DBIT{1'b0}};
      tx_data_r  <= {DBIT{1'b0}};
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      op_error_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      if (load_a_s) a_r <= i_rx_data;
      if (load_b_s) b_r <= i_rx_data;
      if (load_op_s) tx_data_r <= result_s;
      tx_start_r <= (state_n == SEND);
      busy_r     <= (state_n == SEND) || (state_n == WAIT_TX);
      op_error_r <= load_op_s & ~op_ok_s;
      overrun_r  <= drop_s;
    end
  end

  assign o_tx_start = tx_start_r;
  assign o_tx_data  = tx_data_r;
  assign o_busy     = busy_r;
  assign o_op_error = op_error_r;
  assign o_overrun  = overrun_r;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface: directed and random frames are checked
// against an arithmetic reference model by an independent output monitor.
module tb_uart_alu_interface;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_tick;
  logic [7:0] rx_data;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       op_error;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int exp_overrun = 0;
  int seen_overrun = 0;
  logic [8:0] exp_q[$];
  logic [7:0] held = 8'h00;

  always #5 clk = ~clk;

  uart_alu_interface #(.DBIT(8), .NB_OP(6)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_done_tick(rx_tick), .i_rx_data(rx_data),
    .i_tx_done_tick(tx_done), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .o_busy(busy), .o_op_error(op_error), .o_overrun(overrun)
  );

  // Reference: {error, result} from the opcode table with plain integer arithmetic.
  function automatic logic [8:0] ref_alu(input int a, input int b, input int opb);
    int op = opb % 64;
    int r = 0;
    int sa;
    logic err = 1'b0;
    case (op)
      32: r = (a + b) % 256;
      34: r = (a - b + 256) % 256;
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = 255 - (a | b);
      3: begin
        sa = (a >= 128) ? a - 256 : a;
        if (b >= 8) r = (a >= 128) ? 255 : 0;
        else        r = (sa >>> b) & 255;
      end
      2: r = (b >= 8) ? 0 : (a >> b);
      default: begin r = 0; err = 1'b1; end
    endcase
    return {err, r[7:0]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_tick = 1'b1;
    @(negedge clk);
    rx_tick = 1'b0;
  endtask

  // mode 0: plain; 1: extra byte while waiting for TX; 2: RX tick together with TX done.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int mode);
    int n = 0;
    exp_q.push_back(ref_alu(int'(a), int'(b), int'(opb)));
    send_byte(a);
    idle($urandom_range(0, 2));
    send_byte(b);
    idle($urandom_range(0, 2));
    send_byte(opb);
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("busy_after_frame", int'(busy), 1);
    idle($urandom_range(0, 3));
    if (mode == 1) begin
      send_byte(8'hAA);
      exp_overrun++;
    end
    @(negedge clk);
    tx_done = 1'b1;
    if (mode == 2) begin
      rx_data = 8'h55;
      rx_tick = 1'b1;
      exp_overrun++;
    end
    @(negedge clk);
    tx_done = 1'b0;
    rx_tick = 1'b0;
    chk("busy_after_done", int'(busy), 0);
  endtask

  // Monitor: pops the scoreboard on every tx_start and watches hold/pulse behaviour.
  always @(negedge clk) begin
    logic [8:0] exp;
    if (rst_n) begin
      if (tx_start) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tx_start: data 0x%0h with empty scoreboard", tx_data);
        end else begin
          exp = exp_q.pop_front();
          checks++;
          if (tx_data !== exp[7:0] || op_error !== exp[8]) begin
            errors++;
            $display("FAIL result: got data 0x%0h err %0b expected data 0x%0h err %0b",
                     tx_data, op_error, exp[7:0], exp[8]);
          end
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_start: got %0b expected 1", busy);
          end
        end
        held = tx_data;
      end else if (busy) begin
        checks++;
        if (tx_data !== held) begin
          errors++;
          $display("FAIL tx_data_hold: got 0x%0h expected 0x%0h", tx_data, held);
        end
      end
      if (op_error && !tx_start) begin
        checks++;
        errors++;
        $display("FAIL op_error_timing: got pulse without tx_start expected none");
      end
      if (overrun) seen_overrun++;
    end
  end

  logic [7:0] ops [10] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02, 8'h3F, 8'h11};

  initial begin
    logic [7:0] a, b, o;
    rst_n = 1'b0;
    rx_tick = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b0;
    idle(3);
    chk("reset_tx_start", int'(tx_start), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_tx_data", int'(tx_data), 0);
    rst_n = 1'b1;
    idle(2);

    run_frame(8'h05, 8'h03, 8'h20, 0);
    run_frame(8'h03, 8'h05, 8'h22, 0);
    run_frame(8'hFF, 8'h02, 8'h20, 0);
    run_frame(8'h80, 8'h02, 8'h03, 0);
    run_frame(8'h80, 8'h02, 8'h02, 0);
    run_frame(8'h80, 8'h09, 8'h03, 0);
    run_frame(8'h80, 8'h09, 8'h02, 0);
    run_frame(8'h0F, 8'hF0, 8'hE7, 0);
    run_frame(8'h12, 8'h34, 8'h3F, 0);
    run_frame(8'h77, 8'h66, 8'h20, 1);
    run_frame(8'h01, 8'h01, 8'h20, 0);
    run_frame(8'h40, 8'h01, 8'h26, 2);
    // Stray TX done while idle must be ignored.
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    run_frame(8'h30, 8'h0F, 8'h25, 0);

    // Reset after A and B: outputs clear at once, then a fresh frame computes cleanly.
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_tx_data", int'(tx_data), 0);
    chk("midreset_tx_start", int'(tx_start), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_op_error", int'(op_error), 0);
    chk("midreset_overrun", int'(overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(8'h01, 8'h02, 8'h20, 0);

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      o = ops[$urandom_range(0, 9)];
      o[7:6] = 2'($urandom_range(0, 3));
      run_frame(a, b, o, int'($urandom_range(0, 5) == 0));
    end

    idle(5);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("overrun_count", seen_overrun, exp_overrun);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
